// File: rtl/vc_sched_pkg.sv
// Shared definitions for the VC pop scheduler: FSM encoding, destination-bit index
// and the default weight.
package vc_sched_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServe0 = 2'd1,
    StServe1 = 2'd2
  } sched_state_e;

  localparam int unsigned DefaultWeight = 1;

  function automatic int unsigned dest_bit(input int unsigned data_width);
    return data_width - 2;
  endfunction

endpackage

// File: rtl/vc_eligibility.sv
// Per-VC eligibility: the head word may be popped when its FIFO is non-empty and the
// destination it selects is not almost full.
module vc_eligibility
  import vc_sched_pkg::*;
#(
  parameter int unsigned data_width = 6
) (
  input  logic                  empty,
  input  logic [data_width-1:0] head,
  input  logic                  almost_full_d0,
  input  logic                  almost_full_d1,
  output logic                  elig,
  output logic                  dest
);

  localparam int unsigned DestIdx = dest_bit(data_width);

  // Only the destination bit matters here; the rest of the word is carried by the top.
  logic unused_head;
  assign unused_head = ^head;

  assign dest = head[DestIdx];
  assign elig = !empty && !(dest ? almost_full_d1 : almost_full_d0);

endmodule

// File: rtl/vc_pop_scheduler.sv
// Weighted round-robin pop scheduler from VC0/VC1 into D0/D1 with one-cycle registered push.
// Optional per-VC saturating pop counters are enabled by defining VC_SCHED_STATS_EN.
module vc_pop_scheduler
  import vc_sched_pkg::*;
#(
  parameter int unsigned data_width   = 6,
  parameter int unsigned weight_width = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [weight_width-1:0] weight_VC0,
  input  logic [weight_width-1:0] weight_VC1,
  input  logic                    empty_fifo_VC0,
  input  logic                    empty_fifo_VC1,
  input  logic [data_width-1:0]   data_out_VC0,
  input  logic [data_width-1:0]   data_out_VC1,
  input  logic                    almost_full_fifo_D0,
  input  logic                    almost_full_fifo_D1,
  output logic                    pop_VC0_fifo,
  output logic                    pop_VC1_fifo,
  output logic                    push_D0,
  output logic                    push_D1,
  output logic [data_width-1:0]   data_to_D,
  output logic                    grant_vc,
`ifdef VC_SCHED_STATS_EN
  output logic [7:0]              pop_count_VC0,
  output logic [7:0]              pop_count_VC1,
`endif
  output logic                    active_out
);

  localparam logic [weight_width-1:0] WeightOne = weight_width'(DefaultWeight);

  sched_state_e            state_q, state_d;
  logic [weight_width-1:0] cnt_q, cnt_d;
  logic [weight_width-1:0] w0_q, w0_d, w1_q, w1_d;

  logic elig0, elig1, dest0, dest1;
  logic pop0, pop1;
  logic take_own, take_other;
  logic serve1, own_elig, other_elig, exhausted;
  logic [weight_width-1:0] own_w;

  vc_eligibility #(
    .data_width(data_width)
  ) u_elig_vc0 (
    .empty         (empty_fifo_VC0),
    .head          (data_out_VC0),
    .almost_full_d0(almost_full_fifo_D0),
    .almost_full_d1(almost_full_fifo_D1),
    .elig          (elig0),
    .dest          (dest0)
  );

  vc_eligibility #(
    .data_width(data_width)
  ) u_elig_vc1 (
    .empty         (empty_fifo_VC1),
    .head          (data_out_VC1),
    .almost_full_d0(almost_full_fifo_D0),
    .almost_full_d1(almost_full_fifo_D1),
    .elig          (elig1),
    .dest          (dest1)
  );

  // "Own" is the VC currently being served, "other" the one we would switch to.
  assign serve1     = (state_q == StServe1);
  assign own_elig   = serve1 ? elig1 : elig0;
  assign other_elig = serve1 ? elig0 : elig1;
  assign own_w      = serve1 ? w1_q : w0_q;
  assign exhausted  = (cnt_q >= own_w);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    pop0       = 1'b0;
    pop1       = 1'b0;
    take_own   = 1'b0;
    take_other = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (init) begin
          w0_d = (weight_VC0 == '0) ? WeightOne : weight_VC0;
          w1_d = (weight_VC1 == '0) ? WeightOne : weight_VC1;
        end else if (elig0) begin
          pop0    = 1'b1;
          state_d = StServe0;
          cnt_d   = WeightOne;
        end else if (elig1) begin
          pop1    = 1'b1;
          state_d = StServe1;
          cnt_d   = WeightOne;
        end
      end
      StServe0, StServe1: begin
        if (own_elig && !exhausted) begin
          take_own = 1'b1;
          cnt_d    = cnt_q + WeightOne;
        end else if (other_elig) begin
          take_other = 1'b1;
          state_d    = serve1 ? StServe0 : StServe1;
          cnt_d      = WeightOne;
        end else if (own_elig) begin
          // Quota spent but nobody else wants service: restart the burst.
          take_own = 1'b1;
          cnt_d    = WeightOne;
        end else begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        pop0 = serve1 ? take_other : take_own;
        pop1 = serve1 ? take_own : take_other;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign pop_VC0_fifo = pop0 && !reset;
  assign pop_VC1_fifo = pop1 && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      w0_q       <= WeightOne;
      w1_q       <= WeightOne;
      push_D0    <= 1'b0;
      push_D1    <= 1'b0;
      data_to_D  <= '0;
      grant_vc   <= 1'b0;
      active_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w0_q       <= w0_d;
      w1_q       <= w1_d;
      push_D0    <= (pop0 && !dest0) || (pop1 && !dest1);
      push_D1    <= (pop0 && dest0) || (pop1 && dest1);
      active_out <= (state_d != StIdle);
      if (pop0) begin
        data_to_D <= data_out_VC0;
        grant_vc  <= 1'b0;
      end else if (pop1) begin
        data_to_D <= data_out_VC1;
        grant_vc  <= 1'b1;
      end
    end
  end

`ifdef VC_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_count_VC0 <= 8'd0;
      pop_count_VC1 <= 8'd0;
    end else if (state_q == StIdle && init) begin
      pop_count_VC0 <= 8'd0;
      pop_count_VC1 <= 8'd0;
    end else begin
      if (pop0 && pop_count_VC0 != 8'hFF) pop_count_VC0 <= pop_count_VC0 + 8'd1;
      if (pop1 && pop_count_VC1 != 8'hFF) pop_count_VC1 <= pop_count_VC1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_pop_scheduler.sv
// Scoreboard bench for vc_pop_scheduler: queue-backed VC FIFOs, quota-based reference
// model for pop decisions, and a separate monitor checking pushes against expectations.
module tb_vc_pop_scheduler;

  localparam int DW = 6;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [WW-1:0] wv0, wv1;
  logic          e0, e1;
  logic [DW-1:0] d0, d1;
  logic          af0, af1;
  logic          pop0, pop1, push0, push1, grant, active;
  logic [DW-1:0] dto;
`ifdef VC_SCHED_STATS_EN
  logic [7:0]    pc0, pc1;
`endif

  vc_pop_scheduler #(
    .data_width  (DW),
    .weight_width(WW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .init               (init),
    .weight_VC0         (wv0),
    .weight_VC1         (wv1),
    .empty_fifo_VC0     (e0),
    .empty_fifo_VC1     (e1),
    .data_out_VC0       (d0),
    .data_out_VC1       (d1),
    .almost_full_fifo_D0(af0),
    .almost_full_fifo_D1(af1),
    .pop_VC0_fifo       (pop0),
    .pop_VC1_fifo       (pop1),
    .push_D0            (push0),
    .push_D1            (push1),
    .data_to_D          (dto),
    .grant_vc           (grant),
`ifdef VC_SCHED_STATS_EN
    .pop_count_VC0      (pc0),
    .pop_count_VC1      (pc1),
`endif
    .active_out         (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          dest;
    logic          vc;
    int            cyc;
  } exp_t;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [DW-1:0] vq0[$];
  logic [DW-1:0] vq1[$];
  exp_t          sb[$];
  int            popseq[$];

  // Reference model: which VC holds the grant, how many pops remain in its quota.
  bit m_busy;
  int m_cur;
  int m_left;
  int m_w[2];
  int m_stat[2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_cur = 0;
    m_left = 0;
    m_w[0] = 1;
    m_w[1] = 1;
    m_stat[0] = 0;
    m_stat[1] = 0;
  endtask

  function automatic logic [DW-1:0] mkword(input bit dest);
    logic [DW-1:0] w;
    w = DW'($urandom);
    w[DW-2] = dest;
    return w;
  endfunction

  // Decide this cycle's pop from the rules; -1 means no pop.
  function automatic int model_step(input bit el0, input bit el1);
    bit el[2];
    int p, o;
    el[0] = el0;
    el[1] = el1;
    p = -1;
    if (!m_busy) begin
      if (init) begin
        m_w[0] = (wv0 == 0) ? 1 : int'(wv0);
        m_w[1] = (wv1 == 0) ? 1 : int'(wv1);
        m_stat[0] = 0;
        m_stat[1] = 0;
      end else if (el[0]) p = 0;
      else if (el[1]) p = 1;
      if (p >= 0) begin
        m_busy = 1'b1;
        m_cur = p;
        m_left = m_w[p] - 1;
      end
    end else begin
      o = 1 - m_cur;
      if (el[m_cur] && m_left > 0) begin
        p = m_cur;
        m_left--;
      end else if (el[o]) begin
        p = o;
        m_cur = o;
        m_left = m_w[o] - 1;
      end else if (el[m_cur]) begin
        p = m_cur;
        m_left = m_w[m_cur] - 1;
      end else begin
        m_busy = 1'b0;
      end
    end
    return p;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    bit el0, el1;
    int p;
    logic [DW-1:0] w;
    e0 = (vq0.size() == 0);
    e1 = (vq1.size() == 0);
    d0 = e0 ? DW'($urandom) : vq0[0];
    d1 = e1 ? DW'($urandom) : vq1[0];
    #4;
    el0 = !e0 && !(d0[DW-2] ? af1 : af0);
    el1 = !e1 && !(d1[DW-2] ? af1 : af0);
    chk("active_out", int'(active), int'(m_busy));
`ifdef VC_SCHED_STATS_EN
    chk("pop_count_VC0", int'(pc0), m_stat[0]);
    chk("pop_count_VC1", int'(pc1), m_stat[1]);
`endif
    p = model_step(el0, el1);
    chk("pop_VC0", int'(pop0), int'(p == 0));
    chk("pop_VC1", int'(pop1), int'(p == 1));
    if (p >= 0) begin
      w = (p == 0) ? vq0.pop_front() : vq1.pop_front();
      sb.push_back('{data: w, dest: w[DW-2], vc: p[0], cyc: cyc});
      popseq.push_back(p);
      if (m_stat[p] < 255) m_stat[p]++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: every push must match the oldest outstanding pop, one cycle later.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (push0 || push1) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_push: got push_D0=%0d push_D1=%0d expected none", push0,
                     push1);
          end else begin
            it = sb.pop_front();
            chk("push_D0", int'(push0), int'(!it.dest));
            chk("push_D1", int'(push1), int'(it.dest));
            chk("data_to_D", int'(dto), int'(it.data));
            chk("grant_vc", int'(grant), int'(it.vc));
            chk("push_latency", cyc, it.cyc + 1);
          end
        end else if (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
          it = sb.pop_front();
          total++;
          bad++;
          $display("FAIL missing_push: got none expected data %0d at cycle %0d", it.data,
                   it.cyc + 1);
        end
      end
    end
  end

  initial begin
    int exp_seq[12];
    exp_seq = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    model_reset();
    reset = 1'b1;
    init = 1'b0;
    wv0 = '0;
    wv1 = '0;
    af0 = 1'b0;
    af1 = 1'b0;
    e0 = 1'b1;
    e1 = 1'b1;
    d0 = '0;
    d1 = '0;
    repeat (3) @(negedge clk);
    // Non-empty, eligible heads during reset must not be popped.
    e0 = 1'b0;
    e1 = 1'b0;
    #1;
    chk("rst_pop_VC0", int'(pop0), 0);
    chk("rst_pop_VC1", int'(pop1), 0);
    chk("rst_push_D0", int'(push0), 0);
    chk("rst_push_D1", int'(push1), 0);
    chk("rst_data_to_D", int'(dto), 0);
    chk("rst_grant_vc", int'(grant), 0);
    chk("rst_active_out", int'(active), 0);
    e0 = 1'b1;
    e1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Weighted 2:1 round-robin, everything to D0.
    init = 1'b1;
    wv0 = 4'd2;
    wv1 = 4'd1;
    cycle();
    init = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vq0.push_back(mkword(1'b0));
      vq1.push_back(mkword(1'b0));
    end
    popseq.delete();
    repeat (16) cycle();
    chk("wrr_pop_count", popseq.size(), 12);
    for (int i = 0; i < 12 && i < popseq.size(); i++) chk("wrr_pop_order", popseq[i], exp_seq[i]);

    // Only VC1, three words to D1.
    popseq.delete();
    for (int i = 0; i < 3; i++) vq1.push_back(mkword(1'b1));
    repeat (6) cycle();
    chk("vc1_only_pops", popseq.size(), 3);
    chk("vc1_only_idle", int'(active), 0);

    // VC0 blocked by D0 backpressure, VC1 flows to D1.
    popseq.delete();
    af0 = 1'b1;
    for (int i = 0; i < 2; i++) vq0.push_back(mkword(1'b0));
    for (int i = 0; i < 4; i++) vq1.push_back(mkword(1'b1));
    repeat (5) cycle();
    chk("bp_vc1_pops", popseq.size(), 4);
    for (int i = 0; i < popseq.size(); i++) chk("bp_vc1_only", popseq[i], 1);
    popseq.delete();
    af0 = 1'b0;
    cycle();
    chk("bp_release_pop", popseq.size(), 1);
    if (popseq.size() > 0) chk("bp_release_vc", popseq[0], 0);
    repeat (3) cycle();

    // Zero weights behave as one: strict alternation.
    init = 1'b1;
    wv0 = 4'd0;
    wv1 = 4'd0;
    cycle();
    init = 1'b0;
    popseq.delete();
    for (int i = 0; i < 5; i++) begin
      vq0.push_back(mkword(1'($urandom)));
      vq1.push_back(mkword(1'($urandom)));
    end
    repeat (14) cycle();
    chk("alt_pop_count", popseq.size(), 10);
    for (int i = 1; i < popseq.size(); i++) chk("alt_order", popseq[i], 1 - popseq[i-1]);

    // Randomised traffic, backpressure and init pulses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0 && vq0.size() < 8) vq0.push_back(mkword(1'($urandom)));
      if ($urandom_range(3) == 0 && vq1.size() < 8) vq1.push_back(mkword(1'($urandom)));
      af0 = ($urandom_range(4) == 0);
      af1 = ($urandom_range(4) == 0);
      init = ($urandom_range(9) == 0);
      wv0 = WW'($urandom_range(3));
      wv1 = WW'($urandom_range(3));
      cycle();
    end
    init = 1'b0;
    af0 = 1'b0;
    af1 = 1'b0;
    repeat (20) cycle();

    // Reset in the middle of a VC0 burst.
    init = 1'b1;
    wv0 = 4'd3;
    cycle();
    init = 1'b0;
    for (int i = 0; i < 4; i++) vq0.push_back(mkword(1'b0));
    cycle();
    e0 = 1'b0;
    d0 = vq0[0];
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_pop_VC0", int'(pop0), 0);
    chk("mid_rst_pop_VC1", int'(pop1), 0);
    chk("mid_rst_push_D0", int'(push0), 0);
    chk("mid_rst_push_D1", int'(push1), 0);
    chk("mid_rst_data_to_D", int'(dto), 0);
    chk("mid_rst_grant_vc", int'(grant), 0);
    chk("mid_rst_active_out", int'(active), 0);
`ifdef VC_SCHED_STATS_EN
    chk("mid_rst_pop_count_VC0", int'(pc0), 0);
`endif
    vq0.delete();
    vq1.delete();
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) cycle();

`ifdef VC_SCHED_STATS_EN
    // Counter saturation.
    init = 1'b1;
    cycle();
    init = 1'b0;
    for (int i = 0; i < 300; i++) vq0.push_back(mkword(1'b0));
    repeat (305) cycle();
    chk("sat_pop_count_VC0", int'(pc0), 255);
    chk("sat_pop_count_VC1", int'(pc1), 0);
`endif

    repeat (3) cycle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_pop_scheduler.md
Name: vc_pop_scheduler

Overview:
Sequences transfers from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1).
- Decides each cycle which VC FIFO to pop, using weighted round-robin.
- Applies per-destination backpressure from the D FIFOs' almost-full flags.
- Registers the popped word and pushes it to the D FIFO selected by its destination bit.
- Replaces the ad-hoc pop logic between the VC stage and the D stage; sits between the initial and final logic stages.

Parameters:
data_width, 6, width of a data word; bit data_width-2 is the destination select.
weight_width, 4, width of the per-VC weight (burst length) fields.

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
init  input  1  while high in IDLE, weights are (re)loaded from weight_VC0/weight_VC1
weight_VC0  input  weight_width  max consecutive pops granted to VC0 (0 treated as 1)
weight_VC1  input  weight_width  max consecutive pops granted to VC1 (0 treated as 1)
empty_fifo_VC0  input  1  VC0 FIFO empty
empty_fifo_VC1  input  1  VC1 FIFO empty
data_out_VC0  input  data_width  VC0 head word, valid combinationally when not empty
data_out_VC1  input  data_width  VC1 head word, valid combinationally when not empty
almost_full_fifo_D0  input  1  D0 cannot accept a new push
almost_full_fifo_D1  input  1  D1 cannot accept a new push
pop_VC0_fifo  output  1  combinational pop strobe to VC0
pop_VC1_fifo  output  1  combinational pop strobe to VC1
push_D0  output  1  registered push strobe to D0
push_D1  output  1  registered push strobe to D1
data_to_D  output  data_width  registered word for D0/D1
grant_vc  output  1  registered: VC served in the last pop (0 = VC0, 1 = VC1)
active_out  output  1  registered: high while the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, active-high), values held until the first clock edge after reset falls:
  - state = IDLE; burst_cnt = 0.
  - Weight registers w0 = w1 = 1.
  - push_D0 = push_D1 = 0; data_to_D = 0; grant_vc = 0; active_out = 0.
  - Pops are 0 while reset is high.
- Eligibility: VCx is eligible when !empty_fifo_VCx and the almost_full flag of its head word's destination is low.
  - data_out_VCx[data_width-2] = 0 selects D0; = 1 selects D1.
- FSM states: IDLE, SERVE0, SERVE1.
  - IDLE:
    - If init=1: load w0/w1 from the ports (0 becomes 1), stay in IDLE, no pops.
    - Else, if VC0 is eligible: go to SERVE0 and pop VC0 this cycle.
    - Else, if VC1 is eligible: go to SERVE1 and pop VC1 this cycle.
  - SERVEx:
    - Pop VCx if it is eligible and burst_cnt < wx; burst_cnt increments on each pop.
    - Switch to the other VC when burst_cnt = wx, or VCx is not eligible, and the other VC is eligible. The switch is work-conserving: the other VC is popped in the same cycle and burst_cnt is set to 1.
    - If burst_cnt = wx and the other VC is not eligible: keep serving VCx with burst_cnt = 1 (burst restarts).
    - If neither VC is eligible: go to IDLE, burst_cnt = 0.
  - At most one pop per cycle. Never pop an empty FIFO. Never pop toward a destination whose almost_full flag is high.
- Datapath: on the cycle after a pop, data_to_D holds the popped word and exactly one of push_D0/push_D1 pulses high for one cycle.
  - Latency from pop to push is 1 cycle.
  - Back-to-back pops give back-to-back pushes.
- Simultaneous events:
  - Both VCs eligible on entry from IDLE: VC0 wins.
  - init asserted outside IDLE is ignored until the FSM returns to IDLE.
- An almost_full rising in the same cycle blocks the pop combinationally in that cycle.
- Reset mid-burst: any pending push is dropped, because the word was already popped. The system-level reset clears all FIFOs, so this is acceptable.

Optional Feature:
VC_SCHED_STATS_EN
- Defined: adds outputs pop_count_VC0 and pop_count_VC1, each 8 bits.
  - Each counter increments on its pop and saturates at 255.
  - Both are cleared by reset and by init in IDLE.
- Undefined: the ports and counters are absent; scheduling behaviour is identical.

Decomposition:
- Shared package vc_sched_pkg holds:
  - the state encoding (IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2);
  - the DEST_BIT index function (data_width-2);
  - the default weight constant 1.
- One sub-module: vc_eligibility, combinational. It takes empty, head word and both almost_full flags, and outputs the elig bit plus the dest bit. It is instantiated once per VC.

Test Plan:
1. Reset, init=1 with weight_VC0=2, weight_VC1=1, then VC0 and VC1 each hold 6 words to D0 with no backpressure -> pop pattern VC0,VC0,VC1,VC0,VC0,VC1,...; each push_D0 follows its pop by 1 cycle with the same data.
2. Only VC1 non-empty, 3 words with dest bit=1 -> FSM goes IDLE→SERVE1, 3 consecutive pop_VC1_fifo, push_D1 on cycles 2–4, then IDLE with active_out=0.
3. VC0 head targets D0 with almost_full_fifo_D0=1, VC1 head targets D1 -> VC1 is served exclusively; after almost_full_fifo_D0 drops, VC0 is popped within 1 cycle.
4. weight_VC0=0 loaded via init -> treated as 1; with both VCs busy the pops strictly alternate.
5. Assert reset mid-burst (SERVE0, burst_cnt=1) -> all outputs are 0 immediately, with no clock edge required; no pushes until new pops occur.
6. VC_SCHED_STATS_EN defined, 300 VC0 pops -> pop_count_VC0 = 255 (saturated), pop_count_VC1 = 0.
